branch_redirect_unit: RTL and testbench

- Sits directly downstream of the branch unit in the execute stage.
- Consumes each resolved branch/jump (taken flag and destination PC) and compares it against the prediction that travelled down the pipe with the instruction.
- On a mispredict: pulses a pipeline flush, then holds a redirect request to fetch until fetch accepts it.
- Emits one predictor-update record per resolved branch that is not squashed.

---
 rtl/branch_redirect_unit.sv | 164 ++++++++++++++++
 tb/tb_branch_redirect_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit
//   Sits after the execute-stage branch unit. Each resolved branch is compared
//   against the prediction that travelled with it. A wrong next-PC causes:
//     - a one-cycle flush pulse;
//     - a redirect request to fetch, held until fetch accepts it;
//     - a short quiesce window in which wrong-path resolutions are dropped.
//   Every accepted resolution also produces one predictor-update record.
//
//   Redirect handshake: o_redirect_valid rises together with the flush pulse.
//   It stays high, with o_redirect_pc stable, until the first cycle in which
//   i_redirect_ready is high; it drops at the following edge. i_redirect_ready
//   has no effect while o_redirect_valid is low.
//
//   Optional feature, enabled by defining BRU_MISPRED_CNT_EN:
//     free-running branch and mispredict counters. When the macro is not
//     defined, both counter ports are tied to 0.
module branch_redirect_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned PC_WIDTH     = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_e,
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic                i_taken,
    input  logic [PC_WIDTH-1:0] i_dest_pc,
    input  logic                i_pred_taken,
    input  logic [PC_WIDTH-1:0] i_pred_pc,
    output logic                o_flush,
    output logic                o_redirect_valid,
    output logic [PC_WIDTH-1:0] o_redirect_pc,
    input  logic                i_redirect_ready,
    output logic                o_upd_valid,
    output logic [PC_WIDTH-1:0] o_upd_pc,
    output logic                o_upd_taken,
    output logic [PC_WIDTH-1:0] o_upd_target,
    output logic                o_upd_mispred,
    output logic [31:0]         o_branch_cnt,
    output logic [31:0]         o_mispred_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_QUIESCE  = 2'd2
    } state_t;

    localparam logic [3:0] QUIESCE_LOAD = 4'(FLUSH_CYCLES);

    state_t              r_state;
    logic [3:0]          r_qcnt;
    logic                r_flush;
    logic                r_redirect_valid;
    logic [PC_WIDTH-1:0] r_redirect_pc;
    logic                r_upd_valid;
    logic [PC_WIDTH-1:0] r_upd_pc;
    logic                r_upd_taken;
    logic [PC_WIDTH-1:0] r_upd_target;
    logic                r_upd_mispred;

    logic w_mispred;
    logic w_accept;
    logic w_unused;

    // The direction prediction does not take part in the mispredict decision;
    // the next-PC comparison covers it.
    assign w_unused  = i_pred_taken;
    assign w_mispred = (i_dest_pc != i_pred_pc);
    assign w_accept  = i_e && (r_state == ST_IDLE);

    // Control FSM with registered flush, redirect and update outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= ST_IDLE;
            r_qcnt           <= '0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_upd_valid      <= 1'b0;
            r_upd_pc         <= '0;
            r_upd_taken      <= 1'b0;
            r_upd_target     <= '0;
            r_upd_mispred    <= 1'b0;
        end else begin
            r_flush     <= 1'b0;
            r_upd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_e) begin
                        r_upd_valid   <= 1'b1;
                        r_upd_pc      <= i_pc;
                        r_upd_taken   <= i_taken;
                        r_upd_target  <= i_dest_pc;
                        r_upd_mispred <= w_mispred;
                        if (w_mispred) begin
                            r_flush          <= 1'b1;
                            r_redirect_valid <= 1'b1;
                            r_redirect_pc    <= i_dest_pc;
                            r_state          <= ST_REDIRECT;
                        end
                    end
                end
                ST_REDIRECT: begin
                    if (i_redirect_ready) begin
                        r_redirect_valid <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_qcnt  <= QUIESCE_LOAD;
                            r_state <= ST_QUIESCE;
                        end
                    end
                end
                ST_QUIESCE: begin
                    if (r_qcnt <= 4'd1) begin
                        r_qcnt  <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_qcnt <= r_qcnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BRU_MISPRED_CNT_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    // Statistics: count accepted resolutions and accepted mispredicts
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_accept) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
            if (w_mispred) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign o_branch_cnt  = r_branch_cnt;
    assign o_mispred_cnt = r_mispred_cnt;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
    assign o_branch_cnt    = 32'd0;
    assign o_mispred_cnt   = 32'd0;
`endif

    assign o_flush          = r_flush;
    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_upd_valid      = r_upd_valid;
    assign o_upd_pc         = r_upd_pc;
    assign o_upd_taken      = r_upd_taken;
    assign o_upd_target     = r_upd_target;
    assign o_upd_mispred    = r_upd_mispred;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Bench for branch_redirect_unit: directed scenarios followed by random
// resolutions, each cycle checked against a behavioural model that tracks
// "redirect outstanding" and "cycles of wrong-path still to drop".
module tb_branch_redirect_unit;

    localparam int unsigned FLUSH = 2;
    localparam int unsigned PCW   = 32;

    logic           i_clk;
    logic           i_rst_n;
    logic           i_e;
    logic [PCW-1:0] i_pc;
    logic           i_taken;
    logic [PCW-1:0] i_dest_pc;
    logic           i_pred_taken;
    logic [PCW-1:0] i_pred_pc;
    logic           o_flush;
    logic           o_redirect_valid;
    logic [PCW-1:0] o_redirect_pc;
    logic           i_redirect_ready;
    logic           o_upd_valid;
    logic [PCW-1:0] o_upd_pc;
    logic           o_upd_taken;
    logic [PCW-1:0] o_upd_target;
    logic           o_upd_mispred;
    logic [31:0]    o_branch_cnt;
    logic [31:0]    o_mispred_cnt;

    branch_redirect_unit #(
        .FLUSH_CYCLES (FLUSH),
        .PC_WIDTH     (PCW)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_e              (i_e),
        .i_pc             (i_pc),
        .i_taken          (i_taken),
        .i_dest_pc        (i_dest_pc),
        .i_pred_taken     (i_pred_taken),
        .i_pred_pc        (i_pred_pc),
        .o_flush          (o_flush),
        .o_redirect_valid (o_redirect_valid),
        .o_redirect_pc    (o_redirect_pc),
        .i_redirect_ready (i_redirect_ready),
        .o_upd_valid      (o_upd_valid),
        .o_upd_pc         (o_upd_pc),
        .o_upd_taken      (o_upd_taken),
        .o_upd_target     (o_upd_target),
        .o_upd_mispred    (o_upd_mispred),
        .o_branch_cnt     (o_branch_cnt),
        .o_mispred_cnt    (o_mispred_cnt)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model
    bit          m_redirect_pending;
    logic [31:0] m_redirect_target;
    int          m_drop_left;
    logic [31:0] m_branches;
    logic [31:0] m_mispreds;
    bit          e_flush;
    bit          e_upd_valid;
    logic [31:0] e_upd_pc;
    bit          e_upd_taken;
    logic [31:0] e_upd_target;
    bit          e_upd_mispred;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_redirect_pending = 0;
        m_redirect_target  = '0;
        m_drop_left        = 0;
        m_branches         = '0;
        m_mispreds         = '0;
        e_flush            = 0;
        e_upd_valid        = 0;
    endtask

    task automatic check_outputs();
        chk("flush", 32'(o_flush), 32'(e_flush));
        chk("redirect_valid", 32'(o_redirect_valid), 32'(m_redirect_pending));
        if (m_redirect_pending) chk("redirect_pc", o_redirect_pc, m_redirect_target);
        chk("upd_valid", 32'(o_upd_valid), 32'(e_upd_valid));
        if (e_upd_valid) begin
            chk("upd_pc", o_upd_pc, e_upd_pc);
            chk("upd_taken", 32'(o_upd_taken), 32'(e_upd_taken));
            chk("upd_target", o_upd_target, e_upd_target);
            chk("upd_mispred", 32'(o_upd_mispred), 32'(e_upd_mispred));
        end
`ifdef BRU_MISPRED_CNT_EN
        chk("branch_cnt", o_branch_cnt, m_branches);
        chk("mispred_cnt", o_mispred_cnt, m_mispreds);
`else
        chk("branch_cnt", o_branch_cnt, 32'd0);
        chk("mispred_cnt", o_mispred_cnt, 32'd0);
`endif
    endtask

    // driver: apply one cycle of inputs, advance the model, check after the edge
    task automatic step(input bit e, input logic [31:0] pc, input bit tk,
                        input logic [31:0] dest, input logic [31:0] pred, input bit rdy);
        i_e              = e;
        i_pc             = pc;
        i_taken          = tk;
        i_dest_pc        = dest;
        i_pred_pc        = pred;
        i_pred_taken     = 1'($urandom_range(0, 1));
        i_redirect_ready = rdy;
        e_flush     = 0;
        e_upd_valid = 0;
        if (m_redirect_pending) begin
            if (rdy) begin
                m_redirect_pending = 0;
                m_drop_left        = FLUSH;
            end
        end else if (m_drop_left > 0) begin
            m_drop_left--;
        end else if (e) begin
            e_upd_valid   = 1;
            e_upd_pc      = pc;
            e_upd_taken   = tk;
            e_upd_target  = dest;
            e_upd_mispred = (dest != pred);
            m_branches++;
            if (dest != pred) begin
                m_mispreds++;
                e_flush            = 1;
                m_redirect_pending = 1;
                m_redirect_target  = dest;
            end
        end
        @(posedge i_clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 32'h0, 0, 32'h0, 32'h0, 0);
    endtask

    initial begin
        i_rst_n          = 1'b0;
        i_e              = 1'b0;
        i_pc             = '0;
        i_taken          = 1'b0;
        i_dest_pc        = '0;
        i_pred_taken     = 1'b0;
        i_pred_pc        = '0;
        i_redirect_ready = 1'b0;
        model_reset();
        #12;
        check_outputs();
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // correct prediction
        step(1, 32'h100, 0, 32'h104, 32'h104, 0);
        idle(1);

        // mispredict, fetch ready immediately, then quiesce and idle
        step(1, 32'h180, 1, 32'h200, 32'h104, 1);
        step(0, 32'h0, 0, 32'h0, 32'h0, 1);
        idle(2);
        step(1, 32'h1a0, 1, 32'h1c0, 32'h1c0, 0);

        // redirect backpressure with resolutions arriving meanwhile
        step(1, 32'h280, 1, 32'h300, 32'h284, 0);
        for (int k = 0; k < 5; k++) step(k % 2 == 0, 32'h400 + 32'(k), 1, 32'h500, 32'h504, 0);
        step(1, 32'h410, 1, 32'h600, 32'h604, 1);
        // quiesce drop, then the first idle cycle accepts
        step(1, 32'h420, 0, 32'h700, 32'h704, 0);
        step(1, 32'h430, 0, 32'h710, 32'h714, 0);
        step(1, 32'h440, 0, 32'h444, 32'h444, 0);

        // back-to-back: correct then mispredict
        step(1, 32'h800, 0, 32'h804, 32'h804, 0);
        step(1, 32'h804, 1, 32'h900, 32'h808, 0);
        idle(2);
        step(0, 32'h0, 0, 32'h0, 32'h0, 1);
        idle(3);

        // asynchronous reset in the middle of REDIRECT
        step(1, 32'ha00, 1, 32'hb00, 32'ha04, 0);
        #2;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_redirect_valid", 32'(o_redirect_valid), 32'd0);
        chk("rst_flush", 32'(o_flush), 32'd0);
        chk("rst_upd_valid", 32'(o_upd_valid), 32'd0);
        chk("rst_branch_cnt", o_branch_cnt, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(1, 32'hc00, 0, 32'hc04, 32'hc04, 0);

        // ten accepted resolutions, three of them mispredicts
        for (int k = 0; k < 10; k++) begin
            if (k == 2 || k == 5 || k == 8) begin
                step(1, 32'hd00 + 32'(k * 4), 1, 32'he00, 32'hd04, 0);
                step(0, 32'h0, 0, 32'h0, 32'h0, 1);
                idle(FLUSH);
            end else begin
                step(1, 32'hd00 + 32'(k * 4), 0, 32'hd10, 32'hd10, 0);
            end
        end

        // random resolutions with random fetch backpressure
        for (int k = 0; k < 500; k++) begin
            logic [31:0] r_pc;
            logic [31:0] r_pred;
            logic [31:0] r_dest;
            r_pc   = {$urandom_range(0, 255), 2'b00};
            r_pred = r_pc + 32'd4;
            r_dest = ($urandom_range(0, 99) < 30) ? {$urandom_range(0, 1023), 2'b00} : r_pred;
            step($urandom_range(0, 99) < 60, r_pc, 1'($urandom_range(0, 1)), r_dest, r_pred,
                 $urandom_range(0, 99) < 50);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
